piezo_sched: RTL and testbench
==============================

# piezo_sched

Tune scheduler for the Segway piezo alarm path. Arbitrates three alarm requesters (battery low, over-speed, normal mode) by fixed priority, sequences the selected tune note by note from a table, and inserts a per-tune repeat gap. Outputs a note period and enable to the downstream tone generator, which produces the complementary piezo drive.

## Interface

- FAST_SIM, default 0: duration unit UNIT = 2^22 clocks when 0 (≈83.9 ms at 50 MHz), 2^8 clocks when 1.
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  reset; one clock, synchronous, active-low
- batt_low  input  1  request, highest priority
- ovr_spd  input  1  request, middle priority
- norm_mode  input  1  request, lowest priority
- note_period  output  15  tone period in clocks; 0 when silent
- tone_en  output  1  tone generator enable
- active  output  2  tune in progress: 0 none, 1 norm, 2 ovr, 3 batt
- tune_done  output  1  one-cycle pulse when the last note of a tune ends

## Operation

- Winner = highest asserted request: batt_low > ovr_spd > norm_mode. None asserted → no winner.
- Note periods (clocks): G6 31888, C7 23889, E7 18961, G7 15944.
- Tunes, six entries each, (note, duration in UNITs):
  - norm: G6 2, C7 2, E7 2, G7 3, E7 1, G7 8; repeat gap 12 UNITs.
  - ovr: G7 1, C7 1, G7 1, C7 1, G7 1, C7 1; repeat gap 0.
  - batt: G7 2, E7 2, C7 2, G6 3, C7 1, G6 8; repeat gap 6 UNITs.
- States: IDLE, LOAD, PLAY, GAP.
  - IDLE: winner present → LOAD with tune = winner, index 0.
  - LOAD: fetch entry 0, clear duration counter → PLAY.
  - PLAY: count clocks; at dur*UNIT−1 advance index and load next entry in the same cycle (no silent cycle between notes). After index 5 expires: pulse tune_done. Then → GAP if gap > 0 and the same tune is still the winner; → LOAD (restart) if gap = 0 and still the winner; otherwise → IDLE.
  - GAP: silent; after gap*UNIT clocks → LOAD if the same tune is still the winner, else IDLE.
- Preemption: in PLAY or GAP, a winner of strictly higher priority than the current tune → LOAD with the new tune next cycle; the current note is cut.
- Current tune's request drops and no higher winner: the current note finishes, then IDLE; tune_done does not pulse unless that note was index 5.
- A lower-priority request never interrupts.
- Duration counter is 26 bits; never wraps inside a valid note.

## Timing

- Reset values: state IDLE, note_period 0, tone_en 0, active 0, tune_done 0, index 0, counters 0.
- All outputs are registered.
- Request seen in IDLE at cycle N: LOAD at N+1; tone_en = 1 with the entry-0 period from N+2.
- In PLAY, tone_en = 1; in IDLE, LOAD and GAP, tone_en = 0 and note_period = 0.
- active updates on entry to LOAD and clears on entry to IDLE.
- rst_n low mid-tune: all registers return to reset values on that clock edge, including any tune_done pulse.
- Simultaneous request rise and note expiry: preemption wins.

## Structure

- Package piezo_pkg holds:
  - state enum
  - tune_t enum {NONE, NORM, OVR, BATT}
  - note period constants
  - per-tune gap constants
- Sub-module piezo_tune_rom, combinational: (tune_t, index[2:0]) → (period[14:0], dur[3:0]).
- Duration/gap counter, FSM and arbitration live in piezo_sched.

## Test plan

All scenarios run with FAST_SIM = 1, UNIT = 256.

- Reset, then norm_mode = 1:
  - tone_en rises 2 cycles later with period 31888.
  - Periods follow 31888, 23889, 18961, 15944, 18961, 15944 for 512, 512, 512, 768, 256, 2048 clocks.
  - tune_done pulses once, then 3072 silent clocks, then the tune restarts.
- ovr_spd held high: tune loops with no silent gap beyond the 1-cycle LOAD; tune_done pulses every 1537 clocks.
- norm_mode playing note 2, then batt_low = 1:
  - Next cycle state is LOAD with active = 3.
  - Two cycles later period = 15944.
- batt_low playing, then ovr_spd and norm_mode asserted: batt tune continues unchanged.
- norm_mode dropped during note 1: note 1 completes its 512 clocks, then IDLE with tone_en = 0 and no tune_done.
- rst_n low for one cycle mid-note: all outputs 0 the next cycle; playback resumes from entry 0 if the request is still asserted.

Source files
------------

// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo alarm tune scheduler.
package piezo_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // Encoding doubles as priority order and as the 'active' output code.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        NORM = 2'd1,
        OVR  = 2'd2,
        BATT = 2'd3
    } tune_t;

    localparam int CNT_W = 26;

    localparam logic [14:0] P_G6 = 15'd31888;
    localparam logic [14:0] P_C7 = 15'd23889;
    localparam logic [14:0] P_E7 = 15'd18961;
    localparam logic [14:0] P_G7 = 15'd15944;

    localparam logic [3:0] GAP_NORM = 4'd12;
    localparam logic [3:0] GAP_OVR  = 4'd0;
    localparam logic [3:0] GAP_BATT = 4'd6;

    // Silent gap, in duration units, inserted before a tune repeats.
    function automatic logic [3:0] tune_gap(input tune_t t);
        case (t)
            NORM:    tune_gap = GAP_NORM;
            OVR:     tune_gap = GAP_OVR;
            BATT:    tune_gap = GAP_BATT;
            default: tune_gap = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/piezo_tune_rom.sv
// Combinational tune table: (tune, note index) -> (period, duration in units).
module piezo_tune_rom
    import piezo_pkg::*;
(
    input  tune_t       tune,
    input  logic [2:0]  index,
    output logic [14:0] period,
    output logic [3:0]  dur
);

    // Table lookup; out-of-range indices and NONE read as a silent zero entry.
    always_comb begin
        period = '0;
        dur    = '0;
        case (tune)
            NORM: begin
                case (index)
                    3'd0: begin period = P_G6; dur = 4'd2; end
                    3'd1: begin period = P_C7; dur = 4'd2; end
                    3'd2: begin period = P_E7; dur = 4'd2; end
                    3'd3: begin period = P_G7; dur = 4'd3; end
                    3'd4: begin period = P_E7; dur = 4'd1; end
                    3'd5: begin period = P_G7; dur = 4'd8; end
                    default: begin period = '0; dur = '0; end
                endcase
            end
            OVR: begin
                if (index <= 3'd5) begin
                    period = index[0] ? P_C7 : P_G7;
                    dur    = 4'd1;
                end
            end
            BATT: begin
                case (index)
                    3'd0: begin period = P_G7; dur = 4'd2; end
                    3'd1: begin period = P_E7; dur = 4'd2; end
                    3'd2: begin period = P_C7; dur = 4'd2; end
                    3'd3: begin period = P_G6; dur = 4'd3; end
                    3'd4: begin period = P_C7; dur = 4'd1; end
                    3'd5: begin period = P_G6; dur = 4'd8; end
                    default: begin period = '0; dur = '0; end
                endcase
            end
            default: begin period = '0; dur = '0; end
        endcase
    end

endmodule

// File: rtl/piezo_sched.sv
// Priority arbitration, note sequencing and repeat gap for the piezo alarm.
module piezo_sched
    import piezo_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        batt_low,
    input  logic        ovr_spd,
    input  logic        norm_mode,
    output logic [14:0] note_period,
    output logic        tone_en,
    output logic [1:0]  active,
    output logic        tune_done
);

    localparam int UNIT_W = FAST_SIM ? 8 : 22;

    state_t            state, nxt_state;
    tune_t             tune, nxt_tune, winner;
    logic [2:0]        idx, nxt_idx, rom_idx;
    logic [CNT_W-1:0]  cnt, nxt_cnt, note_last, gap_last;
    logic [3:0]        dur_q, nxt_dur, rom_dur;
    logic [14:0]       rom_period, nxt_period;
    logic              nxt_en, nxt_done;
    logic [1:0]        nxt_active;
    logic              preempt, still_win;

    // Fixed-priority request arbitration.
    always_comb begin
        if (batt_low)       winner = BATT;
        else if (ovr_spd)   winner = OVR;
        else if (norm_mode) winner = NORM;
        else                winner = NONE;
    end

    assign preempt   = (2'(winner) > 2'(tune));
    assign still_win = (winner == tune);

    // While playing, look one entry ahead so the next note loads on the expiry cycle.
    assign rom_idx   = (state == S_PLAY) ? (idx + 3'd1) : idx;
    assign note_last = (CNT_W'(dur_q) << UNIT_W) - CNT_W'(1);
    assign gap_last  = (CNT_W'(tune_gap(tune)) << UNIT_W) - CNT_W'(1);

    piezo_tune_rom u_rom (
        .tune   (tune),
        .index  (rom_idx),
        .period (rom_period),
        .dur    (rom_dur)
    );

    // Next-state and next-output logic; outputs are registered alongside state.
    always_comb begin
        nxt_state  = state;
        nxt_tune   = tune;
        nxt_idx    = idx;
        nxt_cnt    = cnt;
        nxt_dur    = dur_q;
        nxt_period = note_period;
        nxt_en     = tone_en;
        nxt_active = active;
        nxt_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (winner != NONE) begin
                    nxt_state  = S_LOAD;
                    nxt_tune   = winner;
                    nxt_idx    = 3'd0;
                    nxt_active = winner;
                end
            end
            S_LOAD: begin
                nxt_state  = S_PLAY;
                nxt_cnt    = '0;
                nxt_dur    = rom_dur;
                nxt_period = rom_period;
                nxt_en     = 1'b1;
            end
            S_PLAY, S_GAP: begin
                if (preempt) begin
                    nxt_state  = S_LOAD;
                    nxt_tune   = winner;
                    nxt_idx    = 3'd0;
                    nxt_cnt    = '0;
                    nxt_active = winner;
                    nxt_period = '0;
                    nxt_en     = 1'b0;
                end else if ((state == S_PLAY) && (cnt != note_last)) begin
                    nxt_cnt = cnt + CNT_W'(1);
                end else if ((state == S_GAP) && (cnt != gap_last)) begin
                    nxt_cnt = cnt + CNT_W'(1);
                end else begin
                    // Current note or gap has just expired.
                    nxt_cnt    = '0;
                    nxt_period = '0;
                    nxt_en     = 1'b0;
                    if ((state == S_PLAY) && (idx == 3'd5))
                        nxt_done = 1'b1;
                    if (!still_win) begin
                        nxt_state  = S_IDLE;
                        nxt_tune   = NONE;
                        nxt_idx    = 3'd0;
                        nxt_active = 2'd0;
                    end else if ((state == S_PLAY) && (idx != 3'd5)) begin
                        nxt_idx    = idx + 3'd1;
                        nxt_dur    = rom_dur;
                        nxt_period = rom_period;
                        nxt_en     = 1'b1;
                    end else if ((state == S_PLAY) && (tune_gap(tune) != 4'd0)) begin
                        nxt_state = S_GAP;
                    end else begin
                        nxt_state = S_LOAD;
                        nxt_idx   = 3'd0;
                    end
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tune        <= NONE;
            idx         <= 3'd0;
            cnt         <= '0;
            dur_q       <= 4'd0;
            note_period <= 15'd0;
            tone_en     <= 1'b0;
            active      <= 2'd0;
            tune_done   <= 1'b0;
        end else begin
            state       <= nxt_state;
            tune        <= nxt_tune;
            idx         <= nxt_idx;
            cnt         <= nxt_cnt;
            dur_q       <= nxt_dur;
            note_period <= nxt_period;
            tone_en     <= nxt_en;
            active      <= nxt_active;
            tune_done   <= nxt_done;
        end
    end

endmodule

// File: tb/tb_piezo_sched.sv
// Self-checking bench for piezo_sched with FAST_SIM = 1 (unit = 256 clocks).
module tb_piezo_sched;

    localparam int U = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        batt_low = 1'b0;
    logic        ovr_spd = 1'b0;
    logic        norm_mode = 1'b0;
    logic [14:0] note_period;
    logic        tone_en;
    logic [1:0]  active;
    logic        tune_done;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    int done_q[$];

    // Tune tables: row = tune code (0 none, 1 norm, 2 ovr, 3 batt).
    int per_t [4][6] = '{'{0, 0, 0, 0, 0, 0},
                         '{31888, 23889, 18961, 15944, 18961, 15944},
                         '{15944, 23889, 15944, 23889, 15944, 23889},
                         '{15944, 18961, 23889, 31888, 23889, 31888}};
    int dur_t [4][6] = '{'{0, 0, 0, 0, 0, 0},
                         '{2, 2, 2, 3, 1, 8},
                         '{1, 1, 1, 1, 1, 1},
                         '{2, 2, 2, 3, 1, 8}};
    int gap_t [4] = '{0, 12, 0, 6};

    int norm_p [6] = '{31888, 23889, 18961, 15944, 18961, 15944};
    int norm_l [6] = '{512, 512, 512, 768, 256, 2048};
    int batt_p [5] = '{18961, 23889, 31888, 23889, 31888};
    int batt_l [5] = '{512, 512, 768, 256, 2048};

    // Model state: phase 0 idle, 1 load, 2 play, 3 gap; left = clocks remaining.
    int m_ph = 0, m_tune = 0, m_note = 0, m_left = 0;
    int e_per = 0, e_en = 0, e_act = 0, e_done = 0;

    piezo_sched #(.FAST_SIM(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .batt_low    (batt_low),
        .ovr_spd     (ovr_spd),
        .norm_mode   (norm_mode),
        .note_period (note_period),
        .tone_en     (tone_en),
        .active      (active),
        .tune_done   (tune_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model stepped on each rising edge from the sampled requests.
    always @(posedge clk) begin
        int w;
        cyc++;
        w = batt_low ? 3 : ovr_spd ? 2 : norm_mode ? 1 : 0;
        e_done = 0;
        if (!rst_n) begin
            m_ph = 0; m_tune = 0; m_note = 0; m_left = 0;
            chk_on = 1'b1;
        end else begin
            case (m_ph)
                0: if (w != 0) begin m_ph = 1; m_tune = w; end
                1: begin m_ph = 2; m_note = 0; m_left = dur_t[m_tune][0] * U; end
                default: begin
                    if (w > m_tune) begin
                        m_ph = 1; m_tune = w;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_ph == 2 && m_note == 5) e_done = 1;
                            if (w != m_tune) m_ph = 0;
                            else if (m_ph == 3) m_ph = 1;
                            else if (m_note < 5) begin
                                m_note++;
                                m_left = dur_t[m_tune][m_note] * U;
                            end else if (gap_t[m_tune] > 0) begin
                                m_ph = 3; m_left = gap_t[m_tune] * U;
                            end else m_ph = 1;
                        end
                    end
                end
            endcase
        end
        e_en  = (m_ph == 2) ? 1 : 0;
        e_per = (m_ph == 2) ? per_t[m_tune][m_note] : 0;
        e_act = (m_ph == 0) ? 0 : m_tune;
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model note_period", int'(note_period), e_per);
            chk("model tone_en", int'(tone_en), e_en);
            chk("model active", int'(active), e_act);
            chk("model tune_done", int'(tune_done), e_done);
            if (tune_done) done_q.push_back(cyc);
        end
    end

    task automatic measure(output int per, output int len);
        per = int'(note_period);
        len = 0;
        while (int'(note_period) == per && len < 6000) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic wait_period(input int p, input int budget);
        int n = 0;
        while (int'(note_period) != p && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(note_period) != p) chk("wait_period timeout", int'(note_period), p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        batt_low = 0; ovr_spd = 0; norm_mode = 0; rst_n = 0;
        repeat (2) @(negedge clk);
        chk("reset note_period", int'(note_period), 0);
        chk("reset tone_en", int'(tone_en), 0);
        chk("reset active", int'(active), 0);
        chk("reset tune_done", int'(tune_done), 0);
        rst_n = 1;
    endtask

    initial begin
        int p, l, nd;

        // Norm tune: start latency, note sequence, gap, restart.
        do_reset();
        @(negedge clk); norm_mode = 1;
        @(negedge clk);
        chk("norm load tone_en", int'(tone_en), 0);
        chk("norm load active", int'(active), 1);
        @(negedge clk);
        chk("norm first tone_en", int'(tone_en), 1);
        chk("norm first period", int'(note_period), 31888);
        nd = done_q.size();
        for (int k = 0; k < 6; k++) begin
            measure(p, l);
            chk("norm note period", p, norm_p[k]);
            chk("norm note length", l, norm_l[k]);
        end
        // Silent run is the 3072-clock gap plus the one LOAD cycle.
        measure(p, l);
        chk("norm gap period", p, 0);
        chk("norm gap length", l, 3073);
        chk("norm done pulses", done_q.size() - nd, 1);
        chk("norm restart period", int'(note_period), 31888);

        // Preemption by battery low while norm plays its third note.
        wait_period(18961, 3000);
        batt_low = 1;
        @(negedge clk);
        chk("preempt active", int'(active), 3);
        chk("preempt tone_en", int'(tone_en), 0);
        @(negedge clk);
        chk("preempt period", int'(note_period), 15944);

        // Lower-priority requests do not disturb the battery tune.
        ovr_spd = 1;
        measure(p, l);
        for (int k = 0; k < 5; k++) begin
            measure(p, l);
            chk("batt note period", p, batt_p[k]);
            chk("batt note length", l, batt_l[k]);
            chk("batt active", int'(active) == 0 ? 3 : int'(active), 3);
        end

        // Over-speed loops with only the LOAD cycle between repeats.
        do_reset();
        nd = done_q.size();
        @(negedge clk); ovr_spd = 1;
        for (int n = 0; n < 8000 && done_q.size() < nd + 4; n++) @(negedge clk);
        chk("ovr done count", done_q.size() - nd, 4);
        if (done_q.size() >= nd + 4) begin
            for (int k = 1; k < 4; k++)
                chk("ovr done spacing", done_q[nd + k] - done_q[nd + k - 1], 1537);
        end

        // Norm request dropped during note 1: note completes, then idle, no done.
        do_reset();
        @(negedge clk); norm_mode = 1;
        wait_period(23889, 2000);
        nd = done_q.size();
        repeat (100) @(negedge clk);
        norm_mode = 0;
        measure(p, l);
        chk("drop note length", l + 100, 512);
        chk("drop tone_en", int'(tone_en), 0);
        chk("drop period", int'(note_period), 0);
        chk("drop active", int'(active), 0);
        repeat (2) @(negedge clk);
        chk("drop no done", done_q.size() - nd, 0);

        // Reset mid-note clears everything; playback restarts from entry 0.
        norm_mode = 1;
        wait_period(23889, 2000);
        repeat (10) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("midreset period", int'(note_period), 0);
        chk("midreset tone_en", int'(tone_en), 0);
        chk("midreset active", int'(active), 0);
        chk("midreset tune_done", int'(tune_done), 0);
        rst_n = 1;
        @(negedge clk);
        chk("resume load active", int'(active), 1);
        chk("resume load tone_en", int'(tone_en), 0);
        @(negedge clk);
        chk("resume period", int'(note_period), 31888);
        chk("resume tone_en", int'(tone_en), 1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
